// File: rtl/seq_alu.sv
// seq_alu: registered opcode ALU with iterative MUL/DIV/MOD and accumulator chaining.
// One operation is accepted per start while idle. Single-cycle ops finish on the
// next edge. MUL (shift-add) and DIV/MOD (restoring divider) take W edges.
module seq_alu #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [3:0]     opcode,
  input  logic           use_acc,
  input  logic [W-1:0]   inputA,
  input  logic [W-1:0]   inputB,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] outputC,
  output logic [1:0]     error
);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_CLR  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_XNOR = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_ADD  = 4'b1011;
  localparam logic [3:0] OP_SUB  = 4'b1100;
  localparam logic [3:0] OP_DIV  = 4'b1101;
  localparam logic [3:0] OP_MOD  = 4'b1110;

  localparam int            CW       = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [W-1:0]  ZW       = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ITER = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           accept, finish, iter_op;
  logic [W-1:0]   a_sel;

  // Latched operation and iteration state
  logic [3:0]     op_q;
  logic [W-1:0]   opa_q, opb_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q;    // MUL: running product; DIV/MOD: {remainder, dividend/quotient}
  logic [2*W-1:0] mcand_q;  // MUL: multiplicand shifted left once per step

  // Output registers
  logic           busy_q, done_q;
  logic [2*W-1:0] outc_q, res_d;
  logic [1:0]     err_q, err_d;

  // Datapath intermediates
  logic [2*W-1:0] mul_sum;
  logic [W:0]     div_shift, div_diff;
  logic           div_ge;
  logic [W-1:0]   rem_next, quo_next;
  logic [W:0]     add_full, sub_full;

  // Operand A source and classification of the incoming opcode
  always_comb begin
    a_sel   = use_acc ? outc_q[W-1:0] : inputA;
    iter_op = (opcode == OP_MUL) ||
              (((opcode == OP_DIV) || (opcode == OP_MOD)) && (inputB != ZW));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic with accept/finish strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = iter_op ? S_ITER : S_EXEC;
        end
      end
      S_EXEC: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      S_ITER: begin
        if (cnt_q == CW'(1)) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One multiplier step, one restoring-divider step, and the single-cycle adders
  always_comb begin
    mul_sum   = acc_q + (opb_q[0] ? mcand_q : '0);
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = (div_shift >= {1'b0, opb_q});
    rem_next  = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
    quo_next  = {acc_q[W-2:0], div_ge};
    add_full  = {1'b0, opa_q} + {1'b0, opb_q};
    sub_full  = {1'b0, opa_q} - {1'b0, opb_q};
  end

  // Operand latch at acceptance and iteration stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_NOP;
      opa_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
    end else if (accept) begin
      op_q  <= opcode;
      opa_q <= a_sel;
      opb_q <= inputB;
      cnt_q <= iter_op ? CNT_LOAD : '0;
      if (opcode == OP_MUL) begin
        acc_q   <= '0;
        mcand_q <= {ZW, a_sel};
      end else begin
        // Divider starts with a zero remainder and the dividend in the low half
        acc_q   <= {ZW, a_sel};
        mcand_q <= '0;
      end
    end else if (state_q == S_ITER) begin
      cnt_q <= cnt_q - CW'(1);
      if (op_q == OP_MUL) begin
        acc_q   <= mul_sum;
        mcand_q <= mcand_q << 1;
        opb_q   <= opb_q >> 1;
      end else begin
        acc_q <= {rem_next, quo_next};
      end
    end
  end

  // Result and flags presented at the completion edge
  always_comb begin
    res_d = outc_q;
    err_d = 2'b00;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_CLR:  res_d = '0;
        OP_NOT:  res_d = {ZW, ~opa_q};
        OP_XNOR: res_d = {ZW, ~(opa_q ^ opb_q)};
        OP_NAND: res_d = {ZW, ~(opa_q & opb_q)};
        OP_AND:  res_d = {ZW, opa_q & opb_q};
        OP_OR:   res_d = {ZW, opa_q | opb_q};
        OP_XOR:  res_d = {ZW, opa_q ^ opb_q};
        OP_NOR:  res_d = {ZW, ~(opa_q | opb_q)};
        OP_ADD: begin
          res_d = {ZW, add_full[W-1:0]};
          err_d = {1'b0, add_full[W]};
        end
        OP_SUB: begin
          res_d = {ZW, sub_full[W-1:0]};
          err_d = {1'b0, sub_full[W]};
        end
        // DIV/MOD only reach EXEC on a zero divisor
        OP_DIV, OP_MOD: begin
          res_d = '0;
          err_d = 2'b10;
        end
        default: res_d = outc_q;  // NOP and illegal opcodes hold
      endcase
    end else begin
      case (op_q)
        OP_MUL:  res_d = mul_sum;
        OP_DIV:  res_d = {ZW, quo_next};
        OP_MOD:  res_d = {ZW, rem_next};
        default: res_d = outc_q;
      endcase
    end
  end

  // Output registers: result/flags on completion, busy follows the FSM, done pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      outc_q <= '0;
      err_q  <= 2'b00;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= finish;
      if (finish) begin
        outc_q <= res_d;
        err_q  <= err_d;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign outputC = outc_q;
  assign error   = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed table of operations with hand-computed results, plus
// sequences for start-while-busy, held start, and reset in the middle of a DIV.
module tb_seq_alu;
  localparam int W = 16;

  localparam logic [3:0] NOP = 4'b0000, CLR = 4'b0001, NOT = 4'b0011, XNR = 4'b0100,
                         NAN = 4'b0101, AND = 4'b0110, OR_ = 4'b0111, XOR = 4'b1000,
                         NOR = 4'b1001, MUL = 4'b1010, ADD = 4'b1011, SUB = 4'b1100,
                         DIV = 4'b1101, MOD = 4'b1110, ILF = 4'b1111, IL2 = 4'b0010;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     opcode = 4'h0;
  logic           use_acc = 1'b0;
  logic [W-1:0]   inputA = '0;
  logic [W-1:0]   inputB = '0;
  logic           busy, done;
  logic [2*W-1:0] outputC;
  logic [1:0]     error;

  int n_vec = 0;
  int n_bad = 0;

  seq_alu #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .use_acc(use_acc),
    .inputA(inputA), .inputB(inputB), .busy(busy), .done(done),
    .outputC(outputC), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic        acc;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] c;
    logic [1:0]  e;
    logic [7:0]  lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] op, input logic acc, input logic [15:0] a,
                              input logic [15:0] b, input logic [31:0] c,
                              input logic [1:0] e, input logic [7:0] lat);
    vec_t v;
    v.op = op; v.acc = acc; v.a = a; v.b = b; v.c = c; v.e = e; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one op, wait for done, check latency/result/flags. Returns in the done cycle.
  task automatic do_op(input string nm, input vec_t v, input bit noise);
    int  k;
    bit  got;
    @(negedge clk);
    opcode = v.op; use_acc = v.acc; inputA = v.a; inputB = v.b; start = 1'b1;
    @(posedge clk); #1;
    check({nm, " busy_at_accept"}, 64'(busy), 64'd1);
    k = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      if (noise) begin
        start   = (k == 2) || (k == 7) || (k == 14);
        opcode  = ADD;
        use_acc = 1'b1;
        inputA  = 16'($urandom);
        inputB  = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (done) got = 1'b1;
    end
    if (!got) $display("FAIL %s timeout: no done within 40 cycles", nm);
    check({nm, " latency"}, 64'(k), 64'(v.lat));
    check({nm, " outputC"}, 64'(outputC), 64'(v.c));
    check({nm, " error"},   64'(error),   64'(v.e));
    check({nm, " busy_at_done"}, 64'(busy), 64'd0);
    $display("txn %s op=%b acc=%0d a=0x%h b=0x%h -> C=0x%h err=%b after %0d cycles",
             nm, v.op, v.acc, v.a, v.b, outputC, error, k);
  endtask

  initial begin
    bit saw_done;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst busy",    64'(busy),    64'd0);
    check("rst done",    64'(done),    64'd0);
    check("rst outputC", 64'(outputC), 64'd0);
    check("rst error",   64'(error),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: 17409 = 0x4401, 4616 = 0x1208 (disjoint bit patterns)
    tbl.push_back(mk(ADD, 0, 16'd17409, 16'd4616, 32'd22025,     2'b00, 8'd1));
    tbl.push_back(mk(SUB, 0, 16'd8194,  16'd6144, 32'd2050,      2'b00, 8'd1));
    tbl.push_back(mk(MUL, 0, 16'd1024,  16'd4097, 32'h0040_0400, 2'b00, 8'd16));
    tbl.push_back(mk(DIV, 0, 16'd16384, 16'd1024, 32'd16,        2'b00, 8'd16));
    tbl.push_back(mk(MOD, 0, 16'd16391, 16'd1024, 32'd7,         2'b00, 8'd16));
    tbl.push_back(mk(ADD, 0, 16'hFFFF,  16'h0001, 32'h0,         2'b01, 8'd1));
    tbl.push_back(mk(SUB, 0, 16'h0000,  16'h0001, 32'h0000_FFFF, 2'b01, 8'd1));
    tbl.push_back(mk(DIV, 0, 16'd5,     16'd0,    32'h0,         2'b10, 8'd1));
    tbl.push_back(mk(AND, 0, 16'hF0F0,  16'h0FF0, 32'h0000_00F0, 2'b00, 8'd1));
    tbl.push_back(mk(XNR, 0, 16'h4401,  16'h1208, 32'h0000_A9F6, 2'b00, 8'd1));
    tbl.push_back(mk(NAN, 0, 16'h4401,  16'h1208, 32'h0000_FFFF, 2'b00, 8'd1));
    tbl.push_back(mk(AND, 0, 16'h4401,  16'h1208, 32'h0000_0000, 2'b00, 8'd1));
    tbl.push_back(mk(OR_, 0, 16'h4401,  16'h1208, 32'h0000_5609, 2'b00, 8'd1));
    tbl.push_back(mk(XOR, 0, 16'h4401,  16'h1208, 32'h0000_5609, 2'b00, 8'd1));
    tbl.push_back(mk(NOR, 0, 16'h4401,  16'h1208, 32'h0000_A9F6, 2'b00, 8'd1));
    tbl.push_back(mk(NOT, 0, 16'h4401,  16'h1208, 32'h0000_BBFE, 2'b00, 8'd1));
    tbl.push_back(mk(NOP, 0, 16'h0001,  16'h0002, 32'h0000_BBFE, 2'b00, 8'd1));
    tbl.push_back(mk(CLR, 0, 16'h1111,  16'h2222, 32'h0,         2'b00, 8'd1));
    tbl.push_back(mk(OR_, 0, 16'h1234,  16'h0001, 32'h0000_1235, 2'b00, 8'd1));
    tbl.push_back(mk(ILF, 0, 16'hAAAA,  16'h5555, 32'h0000_1235, 2'b00, 8'd1));
    tbl.push_back(mk(IL2, 0, 16'hAAAA,  16'h5555, 32'h0000_1235, 2'b00, 8'd1));
    tbl.push_back(mk(MUL, 0, 16'hFFFF,  16'hFFFF, 32'hFFFE_0001, 2'b00, 8'd16));
    tbl.push_back(mk(MOD, 0, 16'hFFFF,  16'h0010, 32'd15,        2'b00, 8'd16));
    tbl.push_back(mk(MOD, 0, 16'd7,     16'd0,    32'h0,         2'b10, 8'd1));
    tbl.push_back(mk(MUL, 0, 16'h1234,  16'h0000, 32'h0,         2'b00, 8'd16));
    // Chaining: each op issued in the previous op's done cycle, A from outputC
    tbl.push_back(mk(ADD, 0, 16'd10,    16'd5,    32'd15,        2'b00, 8'd1));
    tbl.push_back(mk(MUL, 1, 16'd999,   16'd3,    32'd45,        2'b00, 8'd16));
    tbl.push_back(mk(MUL, 1, 16'd999,   16'd3,    32'd135,       2'b00, 8'd16));

    foreach (tbl[i]) begin
      do_op($sformatf("vec%0d", i), tbl[i], 1'b0);
    end

    // start pulses and input changes during a MUL must not disturb it (1234*567)
    do_op("mul_noise", mk(MUL, 0, 16'd1234, 16'd567, 32'd699678, 2'b00, 8'd16), 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("mul_noise no_restart", 64'(busy), 64'd0);

    // start held high across done: second op accepted in the done cycle
    @(negedge clk);
    opcode = SUB; inputA = 16'd100; inputB = 16'd1; use_acc = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("hold busy", 64'(busy), 64'd1);
    @(negedge clk);
    opcode = XOR; inputA = 16'h00FF; inputB = 16'h0F0F;
    @(posedge clk); #1;
    check("hold first done",    64'(done),    64'd1);
    check("hold first outputC", 64'(outputC), 64'd99);
    @(posedge clk); #1;
    check("hold second busy", 64'(busy), 64'd1);
    check("hold second done", 64'(done), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("hold second done2",   64'(done),    64'd1);
    check("hold second outputC", 64'(outputC), 64'h0FF0);
    $display("txn hold SUB 100-1 then XOR 0x00FF^0x0F0F -> C=0x%h", outputC);

    // Reset in the middle of DIV 60000/7
    @(negedge clk);
    opcode = DIV; inputA = 16'd60000; inputB = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy",    64'(busy),    64'd0);
    check("midrst done",    64'(done),    64'd0);
    check("midrst outputC", 64'(outputC), 64'd0);
    check("midrst error",   64'(error),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("midrst no_stale_done", 64'(saw_done), 64'd0);
    $display("txn reset during DIV 60000/7 -> C=0x%h busy=%0d", outputC, busy);

    do_op("div_after_rst", mk(DIV, 0, 16'd60000, 16'd7, 32'd8571, 2'b00, 8'd16), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the combinational 16-bit opcode ALU. It accepts one operation per start handshake and registers the result and error flags. MUL, DIV and MOD are computed iteratively over W cycles; all other opcodes complete in one cycle. It adds an accumulator-chaining mode: operand A can be taken from the previous result, so the block sits in the datapath as a small sequential compute unit.

## Interface
- W, 16: operand width, even, ≥4; result width is 2W.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- opcode  in  4  operation; same map as the existing ALU (below).
- use_acc  in  1  at acceptance, operand A = outputC[W-1:0] instead of inputA.
- inputA  in  W  operand A.
- inputB  in  W  operand B.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; outputC and error are valid and updated.
- outputC  out  2W  registered result, held until the next completion.
- error  out  2  [0] carry/borrow on ADD/SUB; [1] divide-by-zero on DIV/MOD.

## Operation
- Opcode map:
  - 0000 NOP: outputC is held.
  - 0001 CLR: outputC=0.
  - 0011 NOT A.
  - 0100 XNOR.
  - 0101 NAND.
  - 0110 AND.
  - 0111 OR.
  - 1000 XOR.
  - 1001 NOR.
  - 1010 MUL.
  - 1011 ADD.
  - 1100 SUB.
  - 1101 DIV.
  - 1110 MOD.
  - 0010 and 1111 are illegal: treated as NOP.
- Operands and opcode are latched at acceptance. Input changes afterwards have no effect.
- Width rules:
  - Logic ops, ADD, SUB, DIV and MOD write outputC[W-1:0]; outputC[2W-1:W]=0.
  - MUL writes the full unsigned 2W product.
  - All arithmetic is unsigned.
- ADD: sum mod 2^W; error[0]=carry out.
- SUB: A−B mod 2^W; error[0]=1 when A<B.
- DIV: quotient. MOD: remainder. Both use a shared restoring divider, one quotient bit per cycle, MSB first.
- MUL: shift-add multiplier, one bit of B per cycle.
- B=0 with DIV or MOD is a divide-by-zero:
  - No iteration is performed; the op completes in 1 cycle.
  - outputC=0, error=2'b10.
- error is rewritten at every completion; bits not applicable to the op are 0. CLR, NOP and illegal opcodes write error=00.
- State machine:
  - IDLE: start accepted → EXEC for single-cycle ops and divide-by-zero; → ITER for MUL, DIV, MOD (counter loaded with W).
  - EXEC → IDLE with done.
  - ITER decrements the counter each edge; it goes → IDLE with done after W edges.
- start while busy=1 is ignored (no queueing) and does not disturb the op in flight.
- Reset (any time, including mid-ITER) aborts the operation and yields:
  - busy=0, done=0.
  - outputC=0, error=00.
  - state=IDLE, counter=0.

## Timing
- Edge 0 is the edge at which start=1 and busy=0 are sampled.
- busy=1 from edge 0 until the result edge.
- Single-cycle ops: result edge is edge 1 (latency 1).
- MUL, DIV, MOD: result edge is edge W (latency W).
- At the result edge outputC and error update and busy falls. done=1 for exactly the following cycle.
- A new start is accepted in the done cycle, giving back-to-back issue:
  - single-cycle ops: throughput 1 op/cycle;
  - iterative ops: one op every W cycles.
- With use_acc=1 on a back-to-back start, operand A is the outputC value just written at the previous result edge.
- Combinational paths: none from inputs to outputs. All outputs are registers.

## Test plan
- W=16 arithmetic, with start 1 cycle:
  - ADD 17409+4616 → done at +1, outputC=22025, error=00.
  - SUB 8194−6144 → 2050.
  - MUL 1024×4097 → done at +16, outputC=0x00400400.
  - DIV 16384/1024 → 16.
  - MOD 16391%1024 → 7.
- Flags:
  - ADD 0xFFFF+1 → outputC=0, error=01.
  - SUB 0−1 → 0xFFFF, error=01.
  - DIV 5/0 → done at +1, outputC=0, error=10.
  - The following AND op clears error to 00.
- Logic and misc ops:
  - XNOR/NAND/AND/OR/XOR/NOR/NOT on 17409 and 4616 match bitwise reference values, upper half 0.
  - NOP holds outputC.
  - CLR zeroes it.
  - opcode 1111 behaves as NOP.
- Handshake:
  - start pulsed during a MUL (cycles 3, 8, 15) is ignored; the MUL result is unchanged.
  - start held high across done → second op accepted in the done cycle.
- Chaining: ADD 10+5, then use_acc=1 MUL ×3 back-to-back → 15, then 45.
- Reset: rst_n low at cycle 7 of DIV 60000/7 → outputs 0 immediately, busy=0. After release, a fresh DIV 60000/7 → 8571 at +16.
